vga_fb_wr_ctl: RTL and testbench

Write-port controller for the VGA frame buffer. Accepts a stream of PPU pixel writes (x, y, 6-bit colour code) through a small FIFO. Owns the frame buffer's single write port and shares it between that stream and a built-in clear engine, which fills the 256x240 visible area with one colour code. It sits between the PPU and the frame buffer write port (ppu_ctl_clk domain), so one clock drives everything.

---
 rtl/vga_fb_wr_ctl_if.sv | 36 +++
 rtl/vga_fb_wr_ctl.sv | 189 ++++++++++++++++++
 tb/tb_vga_fb_wr_ctl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_wr_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_wr_ctl_if
// Description : Bundle of PPU pixel stream, clear control and frame buffer
//               write-port signals for the frame buffer write controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_fb_wr_ctl_if;
    logic        ppu_valid;
    logic        ppu_ready;
    logic [7:0]  ppu_x;
    logic [7:0]  ppu_y;
    logic [5:0]  ppu_code;
    logic        clr_req;
    logic [5:0]  clr_code;
    logic        clr_busy;
    logic        clr_done;
    logic        fb_cs;
    logic [7:0]  fb_x;
    logic [7:0]  fb_y;
    logic [5:0]  fb_code;
    logic [15:0] drop_cnt;

    // Stimulus side: the PPU and whoever requests clears
    modport master (
        output ppu_valid, ppu_x, ppu_y, ppu_code, clr_req, clr_code,
        input  ppu_ready, clr_busy, clr_done, fb_cs, fb_x, fb_y, fb_code, drop_cnt
    );

    // Controller side
    modport slave (
        input  ppu_valid, ppu_x, ppu_y, ppu_code, clr_req, clr_code,
        output ppu_ready, clr_busy, clr_done, fb_cs, fb_x, fb_y, fb_code, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_wr_ctl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_wr_ctl
// Description : Frame buffer write-port arbiter. Queues PPU pixel writes in a
//               small FIFO and shares the single write port with a clear
//               engine that fills the 256x240 visible area with one code.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_wr_ctl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    vga_fb_wr_ctl_if.slave bus
);

    localparam int               c_AW     = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_FULL   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       c_X_LAST = 8'd255;
    localparam logic [7:0]       c_Y_LAST = 8'd239;
    localparam logic [15:0]      c_DROP_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [21:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic [7:0]        r_clr_x;
    logic [7:0]        r_clr_y;
    logic [5:0]        r_clr_code;
    logic              r_clr_busy;
    logic              r_clr_done;

    logic              r_fb_cs;
    logic [7:0]        r_fb_x;
    logic [7:0]        r_fb_y;
    logic [5:0]        r_fb_code;
    logic [15:0]       r_drop_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_clr_wr;
    logic              w_sweep_last;
    logic [21:0]       w_rd_data;

    // Ready ignores state so PPU beats keep queueing during a clear
    assign w_ready      = (r_count != c_FULL) && !rst;
    assign w_accept     = bus.ppu_valid && w_ready;
    assign w_legal      = (bus.ppu_y <= c_Y_LAST);
    assign w_push       = w_accept && w_legal;
    assign w_drop       = w_accept && !w_legal;
    assign w_sweep_last = (r_clr_x == c_X_LAST) && (r_clr_y == c_Y_LAST);
    assign w_rd_data    = r_mem[r_rd_ptr];

    // Next state and port-ownership decode; a clear request overrides both sources
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_clr_wr    = 1'b0;
        if (bus.clr_req) begin
            w_state_nxt = CLEAR;
        end else begin
            case (r_state)
                IDLE: begin
                    w_pop = (r_count != '0);
                end
                CLEAR: begin
                    w_clr_wr = 1'b1;
                    if (w_sweep_last) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.ppu_x, bus.ppu_y, bus.ppu_code};
        end
    end

    // FIFO pointers and occupancy; a clear flushes all old entries but keeps a same-edge push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (bus.clr_req) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= {{c_AW{1'b0}}, w_push};
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                r_count <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
            end
        end
    end

    // Clear sweep counters and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_x    <= '0;
            r_clr_y    <= '0;
            r_clr_code <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_fb_cs    <= 1'b0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_code  <= '0;
        end else begin
            r_clr_done <= 1'b0;
            r_fb_cs    <= 1'b0;
            if (bus.clr_req) begin
                r_clr_code <= bus.clr_code;
                r_clr_x    <= '0;
                r_clr_y    <= '0;
                r_clr_busy <= 1'b1;
            end else if (w_clr_wr) begin
                r_fb_cs   <= 1'b1;
                r_fb_x    <= r_clr_x;
                r_fb_y    <= r_clr_y;
                r_fb_code <= r_clr_code;
                r_clr_x   <= r_clr_x + 8'd1;
                if (r_clr_x == c_X_LAST) begin
                    r_clr_y <= r_clr_y + 8'd1;
                end
                if (w_sweep_last) begin
                    r_clr_done <= 1'b1;
                    r_clr_busy <= 1'b0;
                end
            end else if (w_pop) begin
                r_fb_cs <= 1'b1;
                {r_fb_x, r_fb_y, r_fb_code} <= w_rd_data;
            end
        end
    end

    // Saturating count of handshaken pixels with an off-screen row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.ppu_ready = w_ready;
    assign bus.clr_busy  = r_clr_busy;
    assign bus.clr_done  = r_clr_done;
    assign bus.fb_cs     = r_fb_cs;
    assign bus.fb_x      = r_fb_x;
    assign bus.fb_y      = r_fb_y;
    assign bus.fb_code   = r_fb_code;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_wr_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_wr_ctl
// Description : Directed self-checking bench for vga_fb_wr_ctl with an
//               in-order scoreboard of expected frame buffer writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_wr_ctl;

    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_fb_wr_ctl_if bus ();

    vga_fb_wr_ctl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks    = 0;
    int          n_pass      = 0;
    int          n_fail      = 0;
    int          drops_total = 0;
    logic [22:0] sb [$];          // {done, x, y, code}
    logic [22:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        bus.ppu_valid = v;
        bus.ppu_x     = x;
        bus.ppu_y     = y;
        bus.ppu_code  = c;
    endtask

    task automatic push_exp(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        sb.push_back({1'b0, x, y, c});
    endtask

    task automatic push_sweep(input logic [5:0] c, input int n, input bit done_last);
        for (int i = 0; i < n; i++) begin
            sb.push_back({1'(done_last && (i == n - 1)), 8'(i), 8'(i >> 8), c});
        end
    endtask

    function automatic logic [15:0] exp_drop();
        return (drops_total >= 65535) ? 16'hFFFF : 16'(drops_total);
    endfunction

    // Every write on the port must be the next scoreboard entry; clr_done only with a write
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.fb_cs) begin
                mon_exp = (sb.size() != 0) ? sb.pop_front() : 23'h7FFFFF;
                chk("fb_write", {9'b0, bus.clr_done, bus.fb_x, bus.fb_y, bus.fb_code}, {9'b0, mon_exp});
            end else begin
                chk("done_without_write", bus.clr_done, 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr_req  = 1'b0;
        bus.clr_code = '0;
        beat(1'b0, 8'd0, 8'd0, 6'd0);
        repeat (3) tick();

        // Reset state
        chk("rst_ready", bus.ppu_ready, 0);
        chk("rst_fb_cs", bus.fb_cs, 0);
        chk("rst_fb_xyc", {bus.fb_x, bus.fb_y, bus.fb_code}, 0);
        chk("rst_busy", bus.clr_busy, 0);
        chk("rst_done", bus.clr_done, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.ppu_ready, 1);

        // Three back-to-back pixels, first write two edges after first accept
        beat(1'b1, 8'd10, 8'd20, 6'h18); push_exp(8'd10, 8'd20, 6'h18); tick();
        chk("px_cs_e1", bus.fb_cs, 0);
        beat(1'b1, 8'd11, 8'd20, 6'h19); push_exp(8'd11, 8'd20, 6'h19); tick();
        chk("px_cs_e2", bus.fb_cs, 1);
        beat(1'b1, 8'd255, 8'd239, 6'h3F); push_exp(8'd255, 8'd239, 6'h3F); tick();
        chk("px_cs_e3", bus.fb_cs, 1);
        beat(1'b0, 8'd0, 8'd0, 6'd0); tick();
        chk("px_cs_e4", bus.fb_cs, 1);
        tick();
        chk("px_cs_e5", bus.fb_cs, 0);
        chk("px_sb_empty", sb.size(), 0);

        // Off-screen row is handshaken and counted, legal row is written
        beat(1'b1, 8'd5, 8'd240, 6'h01); tick(); drops_total++;
        beat(1'b1, 8'd5, 8'd239, 6'h02); push_exp(8'd5, 8'd239, 6'h02); tick();
        beat(1'b0, 8'd0, 8'd0, 6'd0);
        repeat (3) tick();
        chk("drop_one", bus.drop_cnt, 1);
        chk("drop_sb_empty", sb.size(), 0);

        // First clear, interrupted at sweep (100,50); drops streamed meanwhile
        bus.clr_req  = 1'b1;
        bus.clr_code = 6'h05;
        beat(1'b1, 8'd0, 8'd240, 6'd0);
        push_sweep(6'h05, 12900, 1'b0);
        tick(); drops_total++;
        bus.clr_req = 1'b0;
        chk("clr1_busy", bus.clr_busy, 1);
        chk("clr1_no_write_yet", bus.fb_cs, 0);
        for (int k = 1; k <= 12897; k++) begin
            tick(); drops_total++;
        end
        chk("clr1_drop_cnt", bus.drop_cnt, exp_drop());
        chk("clr1_busy_mid", bus.clr_busy, 1);
        // These three are flushed by the restart and must never be written
        beat(1'b1, 8'd1, 8'd1, 6'h11); tick();
        beat(1'b1, 8'd2, 8'd2, 6'h12); tick();
        beat(1'b1, 8'd3, 8'd3, 6'h13); tick();
        chk("clr1_ready_3q", bus.ppu_ready, 1);

        // Restart with new code on the same edge as a kept 4th beat
        bus.clr_req  = 1'b1;
        bus.clr_code = 6'h0F;
        beat(1'b1, 8'd9, 8'd9, 6'h2A);
        push_sweep(6'h0F, 61440, 1'b1);
        push_exp(8'd9, 8'd9, 6'h2A);
        tick();
        bus.clr_req = 1'b0;
        chk("clr2_busy", bus.clr_busy, 1);
        chk("clr2_restart_no_write", bus.fb_cs, 0);

        // Drops until the counter saturates
        beat(1'b1, 8'd0, 8'd240, 6'd0);
        for (int k = 1; k <= 55000; k++) begin
            tick(); drops_total++;
            if (drops_total == 65534) chk("drop_below_max", bus.drop_cnt, 16'hFFFE);
            if (drops_total == 65535) chk("drop_at_max", bus.drop_cnt, 16'hFFFF);
        end
        chk("drop_saturated", bus.drop_cnt, 16'hFFFF);

        // Fill the FIFO during the clear, then hold a 5th beat
        beat(1'b1, 8'd20, 8'd30, 6'h01); push_exp(8'd20, 8'd30, 6'h01); tick();
        beat(1'b1, 8'd21, 8'd30, 6'h02); push_exp(8'd21, 8'd30, 6'h02); tick();
        beat(1'b1, 8'd22, 8'd30, 6'h03); push_exp(8'd22, 8'd30, 6'h03); tick();
        chk("fifo_full_ready", bus.ppu_ready, 0);
        beat(1'b1, 8'd23, 8'd30, 6'h04); push_exp(8'd23, 8'd30, 6'h04);
        repeat (61440 - 55003 - 1) tick();
        chk("clr2_done_before_last", bus.clr_done, 0);
        chk("clr2_busy_before_last", bus.clr_busy, 1);
        tick();
        chk("clr2_done_last", bus.clr_done, 1);
        chk("clr2_busy_falls", bus.clr_busy, 0);
        chk("clr2_last_xy", {bus.fb_cs, bus.fb_x, bus.fb_y, bus.fb_code}, {1'b1, 8'd255, 8'd239, 6'h0F});
        chk("clr2_ready_still_full", bus.ppu_ready, 0);
        tick();
        chk("first_pop_after_clear", {bus.fb_cs, bus.fb_x, bus.fb_y}, {1'b1, 8'd9, 8'd9});
        chk("ready_after_first_pop", bus.ppu_ready, 1);
        tick();
        beat(1'b0, 8'd0, 8'd0, 6'd0);
        chk("second_pop", bus.fb_x, 20);
        repeat (4) tick();
        chk("drain_idle", bus.fb_cs, 0);
        chk("drain_sb_empty", sb.size(), 0);

        // Reset asserted with the sweep counter at (7,3)
        tick();
        bus.clr_req  = 1'b1;
        bus.clr_code = 6'h22;
        push_sweep(6'h22, 774, 1'b0);
        tick();
        bus.clr_req = 1'b0;
        repeat (775) tick();
        chk("clr3_write_6_3", {bus.fb_cs, bus.fb_x, bus.fb_y, bus.fb_code}, {1'b1, 8'd6, 8'd3, 6'h22});
        rst = 1'b1;
        #1;
        chk("midrst_fb_cs", bus.fb_cs, 0);
        chk("midrst_fb_xyc", {bus.fb_x, bus.fb_y, bus.fb_code}, 0);
        chk("midrst_busy_done", {bus.clr_busy, bus.clr_done}, 0);
        chk("midrst_drop", bus.drop_cnt, 0);
        chk("midrst_ready", bus.ppu_ready, 0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_quiet", {bus.fb_cs, bus.clr_busy}, 0);
        end
        chk("post_rst_ready", bus.ppu_ready, 1);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
